// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants, sync polarity constants and clog2.
// Shared by vga_timing_gen, its pixel divider and its output interface.
package vga_timing_pkg;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 29;
    localparam int DEF_PIX_DIV  = 1;
    localparam int MAX_PIX_DIV  = 16;
    localparam bit POL_LOW      = 1'b0;
    localparam bit POL_HIGH     = 1'b1;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_XW       = clog2(DEF_H_TOTAL);
    localparam int DEF_YW       = clog2(DEF_V_TOTAL);
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: video timing bundle between the generator and its consumer.
// master (generator): en in; pix_ce, hsync, vsync, de, x, y, line_start, frame_start out.
// slave (consumer): the mirror image.
interface vga_timing_gen_if
    import vga_timing_pkg::*;
#(
    parameter int XW = DEF_XW,
    parameter int YW = DEF_YW
);
    logic          en;
    logic          pix_ce;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          line_start;
    logic          frame_start;
    modport master (input en, output pix_ce, hsync, vsync, de, x, y, line_start, frame_start);
    modport slave (output en, input pix_ce, hsync, vsync, de, x, y, line_start, frame_start);
endinterface

// File: rtl/pix_strobe.sv
// pix_strobe: divides dclk down to the pixel rate.
// dclk: clock; clr_n: async active-low reset; en: run enable (low holds the phase);
// pix_ce: combinational strobe, high on the enabled dclk that ends a pixel period.
module pix_strobe
    import vga_timing_pkg::*;
#(
    parameter int PIX_DIV = DEF_PIX_DIV
) (
    input  logic dclk,
    input  logic clr_n,
    input  logic en,
    output logic pix_ce
);
    if (PIX_DIV < 1 || PIX_DIV > MAX_PIX_DIV) begin : g_bad_div
        $fatal(1, "pix_strobe: PIX_DIV must be 1..16");
    end
    localparam int DW = (PIX_DIV > 1) ? clog2(PIX_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(PIX_DIV - 1);
    logic [DW-1:0] div;
    assign pix_ce = en && div == LAST;
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) div <= '0;
        else if (en) div <= pix_ce ? '0 : div + 1'b1;
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: programmable raster timing generator (sync, blanking, position, line/frame pulses).
// dclk: clock; clr_n: async active-low reset;
// vif (master): en in; pix_ce, hsync, vsync, de, x, y, line_start, frame_start out,
// all registered one dclk behind the hc/vc counters.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = POL_LOW,
    parameter bit VS_POL   = POL_LOW,
    parameter int PIX_DIV  = DEF_PIX_DIV
) (
    input logic              dclk,
    input logic              clr_n,
    vga_timing_gen_if.master vif
);
    if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
        V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_timing
        $fatal(1, "vga_timing_gen: timing parameters must be non-zero");
    end
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW = clog2(H_TOTAL);
    localparam int YW = clog2(V_TOTAL);
    localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_VIS  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_ON  = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_OFF = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_VIS  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_ON  = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_OFF = YW'(V_ACTIVE + V_FP + V_SYNC);
    logic          adv;
    logic          new_px;
    logic [XW-1:0] hc;
    logic [YW-1:0] vc;
    pix_strobe #(.PIX_DIV(PIX_DIV)) u_strobe (
        .dclk   (dclk),
        .clr_n  (clr_n),
        .en     (vif.en),
        .pix_ce (adv)
    );
    // new_px marks the first enabled dclk on which hc/vc hold a fresh pixel,
    // so line/frame pulses fire once even when a pixel lasts PIX_DIV dclks.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            hc     <= '0;
            vc     <= '0;
            new_px <= 1'b1;
        end else if (vif.en) begin
            new_px <= adv;
            if (adv) begin
                hc <= (hc == H_LAST) ? '0 : hc + 1'b1;
                if (hc == H_LAST) vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
            end
        end
    end
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            vif.pix_ce      <= 1'b0;
            vif.line_start  <= 1'b0;
            vif.frame_start <= 1'b0;
            vif.de          <= 1'b0;
            vif.x           <= '0;
            vif.y           <= '0;
            vif.hsync       <= ~HS_POL;
            vif.vsync       <= ~VS_POL;
        end else begin
            vif.pix_ce      <= adv;
            vif.line_start  <= vif.en && new_px && hc == '0;
            vif.frame_start <= vif.en && new_px && hc == '0 && vc == '0;
            if (vif.en) begin
                vif.x     <= hc;
                vif.y     <= vc;
                vif.de    <= hc < H_VIS && vc < V_VIS;
                vif.hsync <= (hc >= HS_ON && hc < HS_OFF) ? HS_POL : ~HS_POL;
                vif.vsync <= (vc >= VS_ON && vc < VS_OFF) ? VS_POL : ~VS_POL;
            end
        end
    end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC and H_BP, defaults 16, 96 and 48, meaning horizontal front porch, sync and back porch widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, meaning visible lines per frame.
REQ-004 SHALL have parameters V_FP, V_SYNC and V_BP, defaults 10, 2 and 29, meaning vertical front porch, sync and back porch widths in lines.
REQ-005 SHALL have parameters HS_POL and VS_POL, default 0 each, meaning sync assertion level (0 = active-low).
REQ-006 SHALL have parameter PIX_DIV, default 1, meaning dclk cycles per pixel (1..16).
REQ-007 SHALL derive H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800), V_TOTAL likewise (521), XW = clog2(H_TOTAL), YW = clog2(V_TOTAL).
REQ-008 dclk  input  1  sole clock; all state on its rising edge.
REQ-009 clr_n  input  1  asynchronous active-low reset.
REQ-010 en  input  1  synchronous run enable; low freezes all counters.
REQ-011 pix_ce  output  1  one-dclk strobe marking each pixel advance.
REQ-012 hsync, vsync  output  1 each  sync outputs at the HS_POL/VS_POL level.
REQ-013 de  output  1  high while the current pixel is visible.
REQ-014 x  output  XW  horizontal pixel position. y  output  YW  vertical line position.
REQ-015 line_start, frame_start  output  1 each  one-dclk pulses at the start of a line / frame.

Function
REQ-016 Divider: div counts 0..PIX_DIV-1 while en=1 and wraps to 0; pix_ce=1 exactly on the dclk where div==PIX_DIV-1. PIX_DIV=1 SHALL give pix_ce=1 on every enabled cycle.
REQ-017 On pix_ce: hc increments. At hc==H_TOTAL-1, hc wraps to 0 and vc increments. If vc==V_TOTAL-1 at that same edge, both hc and vc wrap to 0.
REQ-018 Line order SHALL be active (hc 0..H_ACTIVE-1), then front porch, then sync, then back porch. The same order applies to vc.
REQ-019 Outputs SHALL be registered and lag the counters by exactly 1 dclk. Each value is held constant for PIX_DIV dclks.
REQ-020 x=hc and y=vc are raw counts, also valid during blanking. de=1 iff hc<H_ACTIVE and vc<V_ACTIVE.
REQ-021 hsync=HS_POL iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC (656..751 by default), else ~HS_POL.
REQ-022 vsync=VS_POL iff V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC (490..491 by default), else ~VS_POL.
REQ-023 line_start SHALL pulse for 1 dclk on the first output cycle with hc==0. frame_start SHALL pulse for 1 dclk on the first output cycle with hc==0 and vc==0, coincident with line_start.
REQ-024 en=0 SHALL hold div, hc, vc and all level outputs, and SHALL force pix_ce, line_start and frame_start to 0. Deassert-then-reassert SHALL resume the sequence with no skipped or repeated pixel.
REQ-025 Any parameter that is zero, or PIX_DIV outside 1..16, SHALL cause a simulation-time fatal error at elaboration.

Reset
REQ-026 clr_n=0 SHALL immediately set div=0, hc=0, vc=0, x=0, y=0, de=0, pix_ce=0, line_start=0, frame_start=0, hsync=~HS_POL and vsync=~VS_POL.
REQ-027 After clr_n rises, the first pix_ce SHALL occur PIX_DIV dclks later. The first frame_start SHALL occur 1 dclk after the first enabled cycle.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no residual pulse on any output.

Structure
REQ-029 Package vga_timing_pkg SHALL hold the default 640x480@60 timing constants, polarity constants and a clog2 function.
REQ-030 The divider SHALL be a sub-module, pix_strobe (parameter PIX_DIV; ports dclk, clr_n, en, pix_ce).

Verification
REQ-031 Defaults, PIX_DIV=1, en=1: hsync low for hc 656..751 (96 dclks), period 800; vsync low for 2 lines; frame period 416800 dclks.
REQ-032 Defaults: de high 640 dclks per line for lines 0..479; x=639 immediately before de falls; exactly 307200 de cycles per frame.
REQ-033 PIX_DIV=4: pix_ce every 4th dclk; x holds each value 4 dclks; line period 3200 dclks.
REQ-034 HS_POL=1, VS_POL=1: sync pulses active-high at the same positions; after reset both read 0.
REQ-035 en=0 for 37 dclks at hc=799, vc=520 -> outputs frozen; on release, frame_start coincides with x=0, y=0; total frame length is 416800+37 dclks.
REQ-036 clr_n pulsed low at hc=700, vc=300 -> all outputs reach reset values asynchronously; the first frame_start follows 1 dclk after release.
